// File: rtl/serializer_piso.sv
// Parallel-in/serial-out stage with a one-word holding buffer.
// Words stream back to back; shift_en freezes the stream.
module serializer_piso #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             data,
  output logic             data_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nx;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_hold_nx;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nx;
  logic             r_hold_full;
  logic             w_hold_full_nx;
  logic             w_accept;
  logic             w_out_bit;
  logic             w_cnt_zero;

  assign load_ready = !r_hold_full;
  assign w_accept   = load_valid && !r_hold_full;
  assign w_cnt_zero = (r_cnt == '0);

  // The vacated end of the register fills with zero.
  assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                               : {1'b0, r_shreg[WIDTH-1:1]};
  assign w_out_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

  // State, shifter, counter and holding buffer registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_shreg     <= w_shreg_nx;
      r_cnt       <= w_cnt_nx;
      r_hold      <= w_hold_nx;
      r_hold_full <= w_hold_full_nx;
    end
  end

  // Next state: load, shift, refill from buffer or direct load.
  always_comb begin
    w_state_nx     = r_state;
    w_shreg_nx     = r_shreg;
    w_cnt_nx       = r_cnt;
    w_hold_nx      = r_hold;
    w_hold_full_nx = r_hold_full;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_shreg_nx = load_data;
          w_cnt_nx   = CNT_MAX;
          w_state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en && w_cnt_zero) begin
          if (r_hold_full) begin
            w_shreg_nx     = r_hold;
            w_cnt_nx       = CNT_MAX;
            w_hold_full_nx = 1'b0;
          end else if (w_accept) begin
            w_shreg_nx = load_data;
            w_cnt_nx   = CNT_MAX;
          end else begin
            w_state_nx = IDLE;
          end
        end else begin
          if (shift_en) begin
            w_shreg_nx = w_shifted;
            w_cnt_nx   = r_cnt - 1'b1;
          end
          if (w_accept) begin
            w_hold_nx      = load_data;
            w_hold_full_nx = 1'b1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Output decode; data is forced low outside SHIFT.
  always_comb begin
    data_valid = (r_state == SHIFT);
    data       = data_valid && w_out_bit;
    last       = data_valid && w_cnt_zero;
    busy       = data_valid || r_hold_full;
  end

endmodule

// File: tb/tb_serializer_piso.sv
// Bench for serializer_piso: two instances (MSB/LSB first)
// checked against a bit-queue model of the stream.
module tb_serializer_piso;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_valid = 1'b0;
  logic         shift_en = 1'b0;

  logic rm, dm, vm, lm, bm;
  logic rl, dl, vl, ll, bl;
  logic [4:0] w_om, w_ol;

  int n_cmp = 0;
  int n_bad = 0;

  bit qm[$];
  bit ql[$];

  serializer_piso #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .reset_n(reset_n),
    .load_data(load_data), .load_valid(load_valid),
    .load_ready(rm), .shift_en(shift_en),
    .data(dm), .data_valid(vm), .last(lm), .busy(bm)
  );

  serializer_piso #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .reset_n(reset_n),
    .load_data(load_data), .load_valid(load_valid),
    .load_ready(rl), .shift_en(shift_en),
    .data(dl), .data_valid(vl), .last(ll), .busy(bl)
  );

  assign w_om = {dm, vm, lm, bm, rm};
  assign w_ol = {dl, vl, ll, bl, rl};

  always #5 clock = ~clock;

  // Words still owning bits in the stage (shifting + held).
  function automatic int occ();
    return (qm.size() + W - 1) / W;
  endfunction

  // Expected {data, data_valid, last, busy, load_ready}.
  function automatic logic [4:0] expv(input bit lsb);
    int  n;
    bit  b;
    n = qm.size();
    b = 1'b0;
    if (n != 0) b = lsb ? ql[0] : qm[0];
    return {b, n != 0, (n % W) == 1, n != 0, occ() < 2};
  endfunction

  task automatic model_step();
    bit acc;
    acc = load_valid && (occ() < 2);
    if (!reset_n) begin
      qm.delete();
      ql.delete();
    end else begin
      if (shift_en && qm.size() != 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          qm.push_back(load_data[W-1-i]);
          ql.push_back(load_data[i]);
        end
      end
    end
  endtask

  always @(posedge clock) model_step();

  task automatic tick(input logic v, input logic [W-1:0] d,
                      input logic s);
    load_valid = v;
    load_data  = d;
    shift_en   = s;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(1'b1, 8'hFF, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (w_om !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_msb got %b want %b", w_om, 5'b00001);
    end
    n_cmp++;
    if (w_ol !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_lsb got %b want %b", w_ol, 5'b00001);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    logic [W-1:0] wd;
    logic [4:0]   ex;
    wd = 8'b0000_1101;
    for (int c = 1; c <= 10; c++) begin
      if (c == 1) tick(1'b1, wd, 1'b1);
      else tick(1'b0, 8'h00, 1'b1);
      ex = {(c <= 8) ? wd[W-c] : 1'b0, c <= 8, c == 8,
            c <= 8, 1'b1};
      n_cmp++;
      if (w_om !== ex) begin
        n_bad++;
        $display("FAIL single c%0d got %b want %b", c, w_om, ex);
      end
      n_cmp++;
      if (w_ol !== expv(1'b1)) begin
        n_bad++;
        $display("FAIL single_lsb c%0d got %b want %b",
                 c, w_ol, expv(1'b1));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] st;
    logic           er;
    st = 16'hA53C;
    for (int c = 1; c <= 18; c++) begin
      if (c == 1) tick(1'b1, 8'hA5, 1'b1);
      else if (c == 3) tick(1'b1, 8'h3C, 1'b1);
      else tick(1'b0, 8'h00, 1'b1);
      er = !(c >= 3 && c <= 8);
      n_cmp++;
      if (c <= 16 && (dm !== st[16-c] || vm !== 1'b1)) begin
        n_bad++;
        $display("FAIL b2b_bit c%0d got %b/%b want %b/1",
                 c, dm, vm, st[16-c]);
      end
      if (c > 16 && vm !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_idle c%0d got %b want 0", c, vm);
      end
      n_cmp++;
      if (rm !== er) begin
        n_bad++;
        $display("FAIL b2b_ready c%0d got %b want %b", c, rm, er);
      end
      n_cmp++;
      if (w_ol !== expv(1'b1)) begin
        n_bad++;
        $display("FAIL b2b_lsb c%0d got %b want %b",
                 c, w_ol, expv(1'b1));
      end
    end
  endtask

  task automatic test_direct_load();
    logic [W-1:0] a, b;
    a = W'($urandom);
    b = W'($urandom);
    for (int c = 1; c <= 17; c++) begin
      if (c == 1) tick(1'b1, a, 1'b1);
      else if (c == 9) tick(1'b1, b, 1'b1);
      else tick(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (vm !== (c <= 16) || rm !== 1'b1) begin
        n_bad++;
        $display("FAIL direct c%0d got v%b r%b want v%b r1",
                 c, vm, rm, c <= 16);
      end
      n_cmp++;
      if (w_om !== expv(1'b0)) begin
        n_bad++;
        $display("FAIL direct_model c%0d got %b want %b",
                 c, w_om, expv(1'b0));
      end
    end
  endtask

  task automatic test_stall();
    logic s;
    for (int c = 1; c <= 12; c++) begin
      s = !(c >= 4 && c <= 6);
      if (c == 1) tick(1'b1, 8'hF0, s);
      else tick(1'b0, 8'h00, s);
      n_cmp++;
      if (dm !== (c <= 7) || lm !== (c == 11) ||
          vm !== (c <= 11)) begin
        n_bad++;
        $display("FAIL stall c%0d got d%b l%b v%b want d%b l%b v%b",
                 c, dm, lm, vm, c <= 7, c == 11, c <= 11);
      end
      n_cmp++;
      if (w_ol !== expv(1'b1)) begin
        n_bad++;
        $display("FAIL stall_lsb c%0d got %b want %b",
                 c, w_ol, expv(1'b1));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] wq[3];
    bit           got[$];
    int           idx;
    int           cyc;
    logic         v, s, acc;
    logic [3*W-1:0] all;
    for (int i = 0; i < 3; i++) wq[i] = W'($urandom);
    all = {wq[0], wq[1], wq[2]};
    idx = 0;
    cyc = 0;
    while ((idx < 3 || qm.size() != 0) && cyc < 300) begin
      v = (idx < 3);
      s = ($urandom_range(3) != 0);
      acc = v && (occ() < 2);
      if (vm && s) got.push_back(dm);
      tick(v, wq[(idx < 3) ? idx : 2], s);
      if (acc) idx++;
      cyc++;
      n_cmp++;
      if (w_om !== expv(1'b0)) begin
        n_bad++;
        $display("FAIL bp_model cyc%0d got %b want %b",
                 cyc, w_om, expv(1'b0));
      end
    end
    n_cmp++;
    if (cyc >= 300) begin
      n_bad++;
      $display("FAIL bp_timeout got %0d cycles want < 300", cyc);
    end
    n_cmp++;
    if (got.size() != 3 * W) begin
      n_bad++;
      $display("FAIL bp_count got %0d want %0d", got.size(), 3 * W);
    end else begin
      for (int i = 0; i < 3 * W; i++) begin
        n_cmp++;
        if (got[i] !== all[3*W-1-i]) begin
          n_bad++;
          $display("FAIL bp_bit%0d got %b want %b",
                   i, got[i], all[3*W-1-i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] wd;
    wd = 8'h81;
    tick(1'b1, 8'hFF, 1'b1);
    tick(1'b1, 8'hEE, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    reset_n = 1'b0;
    tick(1'b0, 8'h00, 1'b1);
    reset_n = 1'b1;
    n_cmp++;
    if (w_om !== 5'b00001 || w_ol !== 5'b00001) begin
      n_bad++;
      $display("FAIL rst_mid got %b/%b want 00001", w_om, w_ol);
    end
    for (int c = 1; c <= 9; c++) begin
      if (c == 1) tick(1'b1, wd, 1'b1);
      else tick(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (dl !== ((c <= 8) ? wd[c-1] : 1'b0) || vl !== (c <= 8)) begin
        n_bad++;
        $display("FAIL rst_after c%0d got d%b v%b want d%b v%b",
                 c, dl, vl, (c <= 8) ? wd[c-1] : 1'b0, c <= 8);
      end
    end
  endtask

  task automatic test_random();
    logic v, s;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(2) != 0);
      s = ($urandom_range(4) != 0);
      reset_n = ($urandom_range(99) != 0);
      tick(v, W'($urandom), s);
      n_cmp++;
      if (w_om !== expv(1'b0) || w_ol !== expv(1'b1)) begin
        n_bad++;
        $display("FAIL random c%0d got %b/%b want %b/%b",
                 c, w_om, w_ol, expv(1'b0), expv(1'b1));
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single();
    tick(1'b0, 8'h00, 1'b1);
    test_back_to_back();
    tick(1'b0, 8'h00, 1'b1);
    test_direct_load();
    tick(1'b0, 8'h00, 1'b1);
    test_stall();
    tick(1'b0, 8'h00, 1'b1);
    test_backpressure();
    tick(1'b0, 8'h00, 1'b1);
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
